// File: rtl/i2s_pkg.sv
// Shared frame geometry and sample types for the I2S master transmitter.
package i2s_pkg;

  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned POS_W      = $clog2(FRAME_BITS);
  localparam int unsigned SBIT_W     = $clog2(SLOT_BITS);
  localparam int unsigned MAX_WL     = 31;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // Samples are held at the widest legal word length; narrower words are zero-extended.
  typedef struct packed {
    logic [MAX_WL-1:0] left;
    logic [MAX_WL-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider and frame bit-position counter; fall_tick_o marks the cycle where BCLK is written 1->0.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             bclk_o,
  output logic [POS_W-1:0] pos_o,
  output logic             fall_tick_o
);

  localparam int unsigned DW = (BCLK_DIV < 2) ? 1 : $clog2(BCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  if (BCLK_DIV < 2) begin : g_bad_div
    $error("i2s_clk_gen: BCLK_DIV must be >= 2");
  end

  logic [DW-1:0]    div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             terminal;
  logic             fall_tick;

  always_comb begin
    terminal  = (div_q == DIV_LAST);
    fall_tick = terminal & bclk_q;
    div_d     = terminal ? '0 : div_q + 1'b1;
    bclk_d    = terminal ? ~bclk_q : bclk_q;
    pos_d     = fall_tick ? pos_q + 1'b1 : pos_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      pos_q  <= '1;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      pos_q  <= pos_d;
    end
  end

  assign bclk_o      = bclk_q;
  assign pos_o       = pos_q;
  assign fall_tick_o = fall_tick;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S bus-master transmitter: one-deep sample holding register feeding a 64-BCLK stereo frame.
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 8,
  parameter int unsigned WL       = 24
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [WL-1:0] dac_left,
  input  logic [WL-1:0] dac_right,
  input  logic          dac_valid,
  output logic          dac_ready,
  output logic          aud_bclk,
  output logic          aud_lrc,
  output logic          aud_dacdat,
  output logic          frame_start,
  output logic          underrun
);

  if (WL < 16 || WL > MAX_WL) begin : g_bad_wl
    $error("i2s_master_tx: WL must be within 16..31");
  end

  logic [POS_W-1:0] pos;
  logic             fall_tick;

  i2s_clk_gen #(.BCLK_DIV(BCLK_DIV)) u_clk_gen (
    .clk_i       (sys_clk),
    .rst_ni      (sys_rst_n),
    .bclk_o      (aud_bclk),
    .pos_o       (pos),
    .fall_tick_o (fall_tick)
  );

  stereo_sample_t    hold_q, hold_d;
  stereo_sample_t    shift_q, shift_d;
  logic              hold_full_q, hold_full_d;
  logic              dacdat_q, dacdat_d;
  logic              hs;
  logic              load;
  logic [POS_W-1:0]  pos_nx;
  logic [SBIT_W-1:0] sbit;
  logic [SBIT_W-1:0] bit_idx;
  chan_e             chan;
  logic [MAX_WL-1:0] word;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    dacdat_d    = dacdat_q;

    hs   = dac_valid & ~hold_full_q;
    load = fall_tick & (pos == POS_W'(FRAME_BITS - 1));

    // Load consumes the old holding state before a same-cycle handshake refills it.
    if (load) begin
      shift_d     = hold_full_q ? hold_q : '0;
      hold_full_d = 1'b0;
    end
    if (hs) begin
      hold_d.left  = MAX_WL'(dac_left);
      hold_d.right = MAX_WL'(dac_right);
      hold_full_d  = 1'b1;
    end

    // Data is driven for the position being entered, giving the one-BCLK I2S delay.
    pos_nx  = pos + 1'b1;
    sbit    = pos_nx[SBIT_W-1:0];
    chan    = chan_e'(pos_nx[POS_W-1]);
    word    = (chan == CH_RIGHT) ? shift_q.right : shift_q.left;
    bit_idx = SBIT_W'(WL) - sbit;
    if (fall_tick) begin
      dacdat_d = ((sbit != '0) && (32'(sbit) <= WL)) ? word[bit_idx] : 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      dacdat_q    <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      dacdat_q    <= dacdat_d;
    end
  end

  assign dac_ready   = ~hold_full_q;
  assign aud_lrc     = pos[POS_W-1];
  assign aud_dacdat  = dacdat_q;
  assign frame_start = load;
  assign underrun    = load & ~hold_full_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench for i2s_master_tx: I2S slave decoder with a frame scoreboard plus directed timing checks.
module tb_i2s_master_tx;

  localparam int BCLK_DIV = 4;
  localparam int WL       = 24;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [WL-1:0] dac_left  = '0;
  logic [WL-1:0] dac_right = '0;
  logic          dac_valid = 1'b0;
  logic          dac_ready, aud_bclk, aud_lrc, aud_dacdat, frame_start, underrun;

  always #5 sys_clk = ~sys_clk;

  i2s_master_tx #(.BCLK_DIV(BCLK_DIV), .WL(WL)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .dac_left    (dac_left),
    .dac_right   (dac_right),
    .dac_valid   (dac_valid),
    .dac_ready   (dac_ready),
    .aud_bclk    (aud_bclk),
    .aud_lrc     (aud_lrc),
    .aud_dacdat  (aud_dacdat),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // rising edges since reset release
  int accepts  = 0;
  int fs_count = 0;
  int ur_count = 0;

  logic [47:0] exp_q[$];
  bit          flag_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  // Accepted pairs become scoreboard entries in acceptance order.
  always @(posedge sys_clk) begin
    if (!sys_rst_n) cyc = 0;
    else            cyc = cyc + 1;
    if (sys_rst_n && dac_valid && dac_ready) begin
      exp_q.push_back({dac_left, dac_right});
      accepts++;
    end
  end

  // I2S slave: samples DACDAT on BCLK rise, frames start at the first rise with LRCK low.
  logic        prev_bclk  = 1'b0;
  logic        prev_lrc   = 1'b1;
  int          idx        = -1;
  logic [63:0] frame_bits = '0;

  task automatic check_frame();
    logic [63:0] expv;
    logic [47:0] p;
    bit          f;
    if (flag_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL frame_flag actual=none required=frame_start before frame (cyc=%0d)", cyc);
      return;
    end
    f = flag_q.pop_front();
    if (f) begin
      expv = '0;
    end else if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL frame_source actual=frame without underrun required=accepted pair (cyc=%0d)", cyc);
      return;
    end else begin
      p    = exp_q.pop_front();
      expv = {1'b0, p[47:24], 7'b0, 1'b0, p[23:0], 7'b0};
    end
    chk("frame_data", frame_bits, expv);
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      idx       = -1;
      prev_bclk = 1'b0;
      prev_lrc  = 1'b1;
      flag_q.delete();
      exp_q.delete();
    end else begin
      if (frame_start) begin
        flag_q.push_back(underrun);
        fs_count++;
      end
      if (underrun) ur_count++;
      if (aud_bclk && !prev_bclk) begin
        if (!aud_lrc && prev_lrc) idx = 0;
        if (idx >= 0) begin
          frame_bits[63-idx] = aud_dacdat;
          idx++;
          if (idx == 64) begin
            check_frame();
            idx = -1;
          end
        end
        prev_lrc = aud_lrc;
      end
      prev_bclk = aud_bclk;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_bclk"},   aud_bclk,    1'b0);
    chk({tag, "_lrc"},    aud_lrc,     1'b1);
    chk({tag, "_dacdat"}, aud_dacdat,  1'b0);
    chk({tag, "_ready"},  dac_ready,   1'b1);
    chk({tag, "_fs"},     frame_start, 1'b0);
    chk({tag, "_ur"},     underrun,    1'b0);
  endtask

  task automatic do_reset();
    tick();
    sys_rst_n = 1'b0;
    dac_valid = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    sys_rst_n = 1'b1;
  endtask

  // Returns the 1-based cycle number (relative to reset release) of the next frame_start.
  task automatic wait_fs(output int c, input int limit);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (frame_start) begin
        c = cyc + 1;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL wait_frame_start actual=timeout required=pulse within %0d cycles", limit);
  endtask

  task automatic wait_lrc_change(output int c, input int limit);
    logic l0;
    l0 = aud_lrc;
    c  = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (aud_lrc !== l0) begin
        c = cyc;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL wait_lrc actual=timeout required=toggle within %0d cycles", limit);
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 20000 && cyc < target; i++) tick();
  endtask

  initial begin
    int c, c0, t1, t2, a0, fs0, ur0, last_acc;
    logic [WL-1:0] n;

    // Idle: zero frames, underrun every frame
    do_reset();
    wait_fs(c, 50);
    chk("first_fall_tick_cycle", c, 8);
    chk("idle_underrun_first", underrun, 1'b1);
    c0 = c;
    wait_fs(c, 600);
    chk("idle_underrun_period", c - c0, 512);
    chk("idle_underrun_second", underrun, 1'b1);
    wait_lrc_change(t1, 400);
    wait_lrc_change(t2, 400);
    chk("lrc_half_period", t2 - t1, 256);

    // Single pair before the first frame
    do_reset();
    a0        = accepts;
    dac_left  = 24'hA5A5A5;
    dac_right = 24'h5A5A5A;
    dac_valid = 1'b1;
    tick();
    dac_valid = 1'b0;
    chk("single_accepted", accepts - a0, 1);
    wait_fs(c, 50);
    chk("single_frame_cycle", c, 8);
    chk("single_no_underrun", underrun, 1'b0);
    wait_fs(c, 600);
    chk("single_next_underrun", underrun, 1'b1);

    // Continuous source for 20 frames
    do_reset();
    fs0       = fs_count;
    ur0       = ur_count;
    n         = '0;
    dac_left  = n;
    dac_right = ~n;
    dac_valid = 1'b1;
    last_acc  = accepts;
    for (int i = 0; i < 12000 && cyc < 10246; i++) begin
      tick();
      if (accepts != last_acc) begin
        last_acc  = accepts;
        n         = n + 1'b1;
        dac_left  = n;
        dac_right = ~n;
      end
    end
    dac_valid = 1'b0;
    chk("stream_frame_starts", fs_count - fs0, 20);
    chk("stream_underruns", ur_count - ur0, 0);

    // Valid held high while not ready
    do_reset();
    a0        = accepts;
    dac_left  = 24'h123456;
    dac_right = 24'hABCDEF;
    dac_valid = 1'b1;
    tick();
    dac_left  = 24'h0F0F0F;
    dac_right = 24'hF0F0F0;
    chk("hold_ready_low", dac_ready, 1'b0);
    wait_fs(c, 50);
    chk("hold_single_accept", accepts - a0, 1);
    chk("hold_ready_at_fs", dac_ready, 1'b0);
    tick();
    chk("hold_ready_after_fs", dac_ready, 1'b1);
    tick();
    dac_valid = 1'b0;
    chk("hold_second_accept", accepts - a0, 2);
    wait_fs(c, 600);
    chk("hold_frame2_no_underrun", underrun, 1'b0);
    wait_fs(c, 600);
    chk("hold_frame3_underrun", underrun, 1'b1);

    // Handshake in the frame-load cycle with holding empty
    do_reset();
    run_until(7);
    chk("coincide_fs", frame_start, 1'b1);
    chk("coincide_underrun", underrun, 1'b1);
    dac_left  = 24'h3C3C3C;
    dac_right = 24'hC3C3C3;
    dac_valid = 1'b1;
    tick();
    dac_valid = 1'b0;
    chk("coincide_held", dac_ready, 1'b0);
    wait_fs(c, 600);
    chk("coincide_next_no_underrun", underrun, 1'b0);
    wait_fs(c, 600);
    chk("coincide_after_underrun", underrun, 1'b1);

    // Reset mid-frame in the right slot with a pair pending
    do_reset();
    a0        = accepts;
    dac_left  = 24'h111111;
    dac_right = 24'h222222;
    dac_valid = 1'b1;
    tick();
    dac_left  = 24'h333333;
    dac_right = 24'h444444;
    for (int i = 0; i < 400 && cyc < 331; i++) begin
      tick();
      if (accepts - a0 >= 2) dac_valid = 1'b0;
    end
    dac_valid = 1'b0;
    chk("midrst_pending", dac_ready, 1'b0);
    chk("midrst_right_slot", aud_lrc, 1'b1);
    sys_rst_n = 1'b0;
    tick();
    check_reset_vals("midrst");
    sys_rst_n = 1'b1;
    wait_fs(c, 50);
    chk("midrst_restart_cycle", c, 8);
    chk("midrst_pair_dropped", underrun, 1'b1);
    wait_fs(c, 600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
